ex_mem_stage: RTL and testbench

//  EX/MEM pipeline stage directly downstream of the 32-bit ALU. Registers ALUResult and control,

---
 rtl/ex_mem_pkg.sv | 53 +++++
 rtl/ex_mem_stage_load_align.sv | 25 ++
 rtl/ex_mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared encodings, pipeline-register payload and lane helpers for the EX/MEM stage.
package ex_mem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned BE_W   = XLEN / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              store;
        logic [1:0]        size;
        logic              uns;
        logic              zero;
    } exmem_op_t;

    // Size 2'b11 falls through to the word encodings in all helpers.
    function automatic logic [BE_W-1:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: byte_enable = 4'b0001 << a;
            SZ_HALF: byte_enable = a[1] ? 4'b1100 : 4'b0011;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [XLEN-1:0] d);
        case (size)
            SZ_BYTE: store_lanes = {4{d[7:0]}};
            SZ_HALF: store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_stage_load_align.sv
// Combinational load lane select with sign or zero extension.
module load_align
    import ex_mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = rdata[{addr, 3'b000} +: 8];
        half_c = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data_c = uns ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
            SZ_HALF: data_c = uns ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: registers ALU results, runs the data-memory handshake, aligns loads.
// Optional bus timeout abort is enabled by defining EXMEM_TIMEOUT_EN.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ALUResult,
    input  logic              Zero,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_load_uns,
    input  logic              flush,
    output logic              ex_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_data,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic              wb_zero,
    output logic              misalign_err
);

    state_e            state_q, state_d;
    exmem_op_t         pipe_q, pipe_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_zero_q, wb_zero_d;
    logic              misalign_err_q, misalign_err_d;
    logic [XLEN-1:0]   load_data_c;

`ifdef EXMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (pipe_q.addr[1:0]),
        .size   (pipe_q.size),
        .uns    (pipe_q.uns),
        .data_c (load_data_c)
    );

    // Next-state and registered-output logic; wb_valid and misalign_err are single-cycle pulses.
    always_comb begin
        state_d        = state_q;
        pipe_d         = pipe_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        wb_zero_d      = wb_zero_q;
        misalign_err_d = 1'b0;
`ifdef EXMEM_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ex_valid && !flush) begin
                    pipe_d.addr      = ALUResult;
                    pipe_d.rd        = ex_rd;
                    pipe_d.reg_write = ex_reg_write;
                    pipe_d.store     = ex_mem_write;
                    pipe_d.size      = ex_mem_size;
                    pipe_d.uns       = ex_load_uns;
                    pipe_d.zero      = Zero;
                    if (!(ex_mem_read || ex_mem_write)) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ALUResult;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_reg_write;
                        wb_zero_d      = Zero;
                    end else if (misaligned(ex_mem_size, ALUResult[1:0])) begin
                        misalign_err_d = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ex_mem_write;
                        mem_addr_d  = {ALUResult[XLEN-1:2], 2'b00};
                        mem_be_d    = byte_enable(ex_mem_size, ALUResult[1:0]);
                        mem_wdata_d = store_lanes(ex_mem_size, ex_store_data);
`ifdef EXMEM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d        = S_RESP;
                    mem_req_d      = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = pipe_q.store ? pipe_q.addr : load_data_c;
                    wb_rd_d        = pipe_q.rd;
                    wb_reg_write_d = pipe_q.reg_write && !pipe_q.store;
                    wb_zero_d      = pipe_q.zero;
                end
`ifdef EXMEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d        = S_IDLE;
                    mem_req_d      = 1'b0;
                    misalign_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            pipe_q         <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_be_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_zero_q      <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pipe_q         <= pipe_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_zero_q      <= wb_zero_d;
            misalign_err_q <= misalign_err_d;
        end
    end

`ifdef EXMEM_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign ex_stall     = (state_q == S_ACCESS) || (state_q == S_RESP);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_zero      = wb_zero_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed table, hand sequences, random ops vs a reference model.
module tb_ex_mem_stage;

    localparam int K_ALU = 0;
    localparam int K_MEM = 1;
    localparam int K_MIS = 2;

`ifdef EXMEM_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 4;
`else
    localparam int unsigned TO_CYCLES = 255;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        rd_en;
        logic        wr_en;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic        reg_write;
        logic        zero;
        int unsigned waits;
        int          kind;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ex_valid;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_load_uns;
    logic        flush;
    logic        ex_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_zero;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    ex_mem_stage #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .Clk(Clk), .Reset(Reset), .ex_valid(ex_valid), .ALUResult(ALUResult), .Zero(Zero),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
        .ex_load_uns(ex_load_uns), .flush(flush), .ex_stall(ex_stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_zero(wb_zero), .misalign_err(misalign_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                                input logic rd_en, input logic wr_en, input logic [1:0] size, input logic uns,
                                input logic [4:0] rd, input logic zero, input int unsigned waits, input int kind,
                                input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] wb);
        vec_t v;
        v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rd_en = rd_en; v.wr_en = wr_en;
        v.size = size; v.uns = uns; v.rd = rd; v.reg_write = 1'b1; v.zero = zero; v.waits = waits;
        v.kind = kind; v.exp_be = be; v.exp_wdata = wdata; v.exp_wb = wb;
        return v;
    endfunction

    // Reference: access width in bytes, alignment by modulo, lanes and extension by shifting and masking.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int unsigned nb;
        int unsigned a;
        logic [63:0] mask;
        logic [63:0] val;
        r = v;
        a = int'(v.addr % 32'd4);
        nb = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        r.exp_be = 4'h0; r.exp_wdata = 32'h0; r.exp_wb = 32'h0;
        if (!(v.rd_en || v.wr_en)) begin
            r.kind = K_ALU;
            r.exp_wb = v.addr;
        end else if ((a % nb) != 0) begin
            r.kind = K_MIS;
        end else begin
            r.kind = K_MEM;
            r.exp_be = 4'(((1 << nb) - 1) << a);
            mask = (64'd1 << (8 * nb)) - 64'd1;
            r.exp_wdata = 32'((64'(v.sdata) & mask) * ((nb == 1) ? 64'h01010101 : (nb == 2) ? 64'h00010001 : 64'd1));
            val = (64'(v.rdata) >> (8 * a)) & mask;
            if (!v.uns && nb < 4 && val >= (mask + 64'd1) / 64'd2) val = val | ~mask;
            r.exp_wb = 32'(val);
        end
        return r;
    endfunction

    // Drive one instruction at a falling edge and follow it to completion; optionally poke upstream during the wait.
    task automatic run_op(input vec_t v, input bit poke);
        int unsigned stalls;
        logic [31:0] exp_addr;
        exp_addr = v.addr & 32'hFFFF_FFFC;
        chk("idle_stall", 32'(ex_stall), 32'd0);
        ex_valid = 1'b1; ALUResult = v.addr; Zero = v.zero; ex_store_data = v.sdata; ex_rd = v.rd;
        ex_reg_write = v.reg_write; ex_mem_read = v.rd_en; ex_mem_write = v.wr_en;
        ex_mem_size = v.size; ex_load_uns = v.uns; flush = 1'b0;
        @(negedge Clk);
        ex_valid = 1'b0;
        if (v.kind == K_ALU) begin
            chk("alu_wb_valid", 32'(wb_valid), 32'd1);
            chk("alu_wb_data", wb_data, v.exp_wb);
            chk("alu_wb_rd", 32'(wb_rd), 32'(v.rd));
            chk("alu_wb_reg_write", 32'(wb_reg_write), 32'(v.reg_write));
            chk("alu_wb_zero", 32'(wb_zero), 32'(v.zero));
            chk("alu_stall", 32'(ex_stall), 32'd0);
            chk("alu_no_req", 32'(mem_req), 32'd0);
        end else if (v.kind == K_MIS) begin
            chk("mis_err", 32'(misalign_err), 32'd1);
            chk("mis_no_req", 32'(mem_req), 32'd0);
            chk("mis_no_wb", 32'(wb_valid), 32'd0);
            chk("mis_stall", 32'(ex_stall), 32'd0);
            @(negedge Clk);
            chk("mis_err_once", 32'(misalign_err), 32'd0);
            chk("mis_no_req2", 32'(mem_req), 32'd0);
        end else begin
            chk("mem_we", 32'(mem_we), 32'(v.wr_en));
            chk("mem_be", 32'(mem_be), 32'(v.exp_be));
            if (v.wr_en) chk("mem_wdata", mem_wdata, v.exp_wdata);
            stalls = 0;
            for (int unsigned i = 0; i <= v.waits; i++) begin
                if (ex_stall) stalls++;
                chk("mem_req_held", 32'(mem_req), 32'd1);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_no_wb_yet", 32'(wb_valid), 32'd0);
                mem_ack = (i == v.waits);
                mem_rdata = (i == v.waits) ? v.rdata : $urandom;
                ex_valid = poke && (i < v.waits);
                flush = poke && (i < v.waits);
                ALUResult = $urandom;
                ex_mem_read = 1'b0; ex_mem_write = 1'b0;
                @(negedge Clk);
            end
            mem_ack = 1'b0; ex_valid = 1'b0; flush = 1'b0;
            if (ex_stall) stalls++;
            chk("resp_req_low", 32'(mem_req), 32'd0);
            chk("resp_wb_valid", 32'(wb_valid), 32'd1);
            chk("resp_wb_rd", 32'(wb_rd), 32'(v.rd));
            chk("resp_wb_reg_write", 32'(wb_reg_write), 32'(v.reg_write && !v.wr_en));
            if (!v.wr_en) chk("load_data", wb_data, v.exp_wb);
            @(negedge Clk);
            chk("post_stall", 32'(ex_stall), 32'd0);
            chk("post_wb_pulse", 32'(wb_valid), 32'd0);
            chk("stall_cycles", stalls, v.waits + 2);
        end
    endtask

    vec_t tbl[15];
    vec_t rv;

    initial begin
        Reset = 1'b1; ex_valid = 1'b0; ALUResult = '0; Zero = 1'b0; ex_store_data = '0; ex_rd = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = 2'b00;
        ex_load_uns = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        tbl[0]  = mk(32'h0000_0005, 32'h0, 32'h0, 0, 0, 2'b10, 0, 5'd8,  0, 0, K_ALU, 4'h0, 32'h0, 32'h0000_0005);
        tbl[1]  = mk(32'h0000_1003, 32'h0, 32'h8012_3456, 1, 0, 2'b00, 0, 5'd9, 0, 3, K_MEM, 4'b1000, 32'h0, 32'hFFFF_FF80);
        tbl[2]  = mk(32'h0000_1003, 32'h0, 32'h8012_3456, 1, 0, 2'b00, 1, 5'd9, 0, 3, K_MEM, 4'b1000, 32'h0, 32'h0000_0080);
        tbl[3]  = mk(32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 1, 2'b01, 0, 5'd10, 0, 0, K_MEM, 4'b1100, 32'hABCD_ABCD, 32'h0);
        tbl[4]  = mk(32'h0000_3001, 32'h0, 32'h0, 1, 0, 2'b10, 0, 5'd11, 0, 0, K_MIS, 4'h0, 32'h0, 32'h0);
        tbl[5]  = mk(32'h0000_4002, 32'h0, 32'h8001_7FFF, 1, 0, 2'b01, 0, 5'd12, 0, 1, K_MEM, 4'b1100, 32'h0, 32'hFFFF_8001);
        tbl[6]  = mk(32'h0000_4000, 32'h0, 32'h8001_F00D, 1, 0, 2'b01, 1, 5'd13, 0, 0, K_MEM, 4'b0011, 32'h0, 32'h0000_F00D);
        tbl[7]  = mk(32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 1, 0, 2'b10, 0, 5'd14, 0, 2, K_MEM, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        tbl[8]  = mk(32'h0000_6001, 32'h0000_00A5, 32'h0, 0, 1, 2'b00, 0, 5'd15, 0, 1, K_MEM, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        tbl[9]  = mk(32'h0000_7004, 32'h1122_3344, 32'h0, 1, 1, 2'b10, 0, 5'd16, 0, 0, K_MEM, 4'b1111, 32'h1122_3344, 32'h0);
        tbl[10] = mk(32'h0000_4001, 32'h0, 32'h0, 1, 0, 2'b01, 0, 5'd17, 0, 0, K_MIS, 4'h0, 32'h0, 32'h0);
        tbl[11] = mk(32'h0000_9002, 32'h0, 32'h0, 1, 0, 2'b11, 0, 5'd18, 0, 0, K_MIS, 4'h0, 32'h0, 32'h0);
        tbl[12] = mk(32'h0000_9004, 32'h0, 32'h00C0_FFEE, 1, 0, 2'b11, 0, 5'd19, 0, 1, K_MEM, 4'b1111, 32'h0, 32'h00C0_FFEE);
        tbl[13] = mk(32'h0000_0000, 32'h0, 32'h0, 0, 0, 2'b00, 0, 5'd31, 1, 0, K_ALU, 4'h0, 32'h0, 32'h0000_0000);
        tbl[14] = mk(32'h0000_1001, 32'h0, 32'h1234_7F56, 1, 0, 2'b00, 0, 5'd20, 0, 0, K_MEM, 4'b0010, 32'h0, 32'h0000_007F);

        @(negedge Clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_stall", 32'(ex_stall), 32'd0);
        chk("rst_err", 32'(misalign_err), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 15; i++) run_op(tbl[i], 1'b0);

        // Back-to-back ALU ops retire one per cycle with no stall.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
                chk("b2b_wb_data", wb_data, 32'h100 + 32'(i - 1));
                chk("b2b_stall", 32'(ex_stall), 32'd0);
            end
            ex_valid = (i < 3); ALUResult = 32'h100 + 32'(i); ex_mem_read = 1'b0; ex_mem_write = 1'b0;
            ex_rd = 5'(i); ex_reg_write = 1'b1;
            @(negedge Clk);
        end
        chk("b2b_end", 32'(wb_valid), 32'd0);

        // Flushed instruction becomes a bubble.
        ex_valid = 1'b1; flush = 1'b1; ALUResult = 32'h77; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        @(negedge Clk);
        ex_valid = 1'b0; flush = 1'b0;
        chk("flush_bubble", 32'(wb_valid), 32'd0);

        // Reset during an access drops mem_req without a clock; a stray ack afterwards is ignored.
        ex_valid = 1'b1; ALUResult = 32'h0000_0100; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_mem_size = 2'b10;
        @(negedge Clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_stall", 32'(ex_stall), 32'd0);
        @(negedge Clk);
        Reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            mem_ack = 1'b0;
            chk("rst_no_wb", 32'(wb_valid), 32'd0);
            chk("rst_idle_req", 32'(mem_req), 32'd0);
            chk("rst_idle_stall", 32'(ex_stall), 32'd0);
        end

`ifdef EXMEM_TIMEOUT_EN
        // No ack: request held four cycles then aborted with an error pulse.
        ex_valid = 1'b1; ALUResult = 32'h0000_0200; ex_mem_read = 1'b1; ex_mem_size = 2'b10;
        @(negedge Clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req_held", 32'(mem_req), 32'd1);
            @(negedge Clk);
        end
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_err", 32'(misalign_err), 32'd1);
        chk("to_no_wb", 32'(wb_valid), 32'd0);
        chk("to_stall_clear", 32'(ex_stall), 32'd0);
        @(negedge Clk);
        chk("to_err_once", 32'(misalign_err), 32'd0);
`endif

        for (int n = 0; n < 60; n++) begin
            int sel;
            rv.addr = $urandom; rv.sdata = $urandom; rv.rdata = $urandom;
            if ($urandom_range(0, 1) == 1) rv.addr = rv.addr & 32'hFFFF_FFFC;
            sel = int'($urandom_range(0, 2));
            rv.wr_en = (sel == 2);
            rv.rd_en = (sel == 1) || (sel == 2 && $urandom_range(0, 3) == 0);
            rv.size = 2'($urandom_range(0, 3));
            rv.uns = 1'($urandom_range(0, 1));
            rv.rd = 5'($urandom);
            rv.reg_write = 1'($urandom_range(0, 1));
            rv.zero = 1'($urandom_range(0, 1));
            rv.waits = $urandom_range(0, 3);
            run_op(model(rv), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
